// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, drives the async instruction memory and
// registers IF outputs, sharing the read port with a debug requester.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_WORDS   = 32,
   parameter int          FETCH_CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [31:0]            redirect_pc_i,
   output logic [31:0]            imem_addr_o,
   input  logic [31:0]            imem_instr_i,
   output logic [31:0]            if_pc_o,
   output logic [31:0]            if_pc4_o,
   output logic [31:0]            if_instr_o,
   output logic                   if_valid_o,
   input  logic                   dbg_req_i,
   input  logic [31:0]            dbg_addr_i,
   output logic                   dbg_gnt_o,
   output logic [31:0]            dbg_data_o,
   output logic [FETCH_CNT_W-1:0] fetch_cnt_o
);

   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic        last_dbg_reg;
   logic        dbg_grant;
   logic        addr_in_range;
   logic [31:0] read_word;

   // last_dbg blocks back-to-back grants so fetch is never starved.
   assign dbg_grant     = dbg_req_i && !last_dbg_reg && !redirect_i && (state_reg != ST_BOOT);
   assign imem_addr_o   = dbg_grant ? {dbg_addr_i[31:2], 2'b00} : pc_reg;
   assign addr_in_range = (imem_addr_o < MEM_BYTES);
   assign read_word     = addr_in_range ? imem_instr_i : 32'h0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= ST_BOOT;
         pc_reg       <= RESET_PC;
         last_dbg_reg <= 1'b0;
         if_pc_o      <= 32'h0;
         if_pc4_o     <= 32'h4;
         if_instr_o   <= 32'h0;
         if_valid_o   <= 1'b0;
         dbg_gnt_o    <= 1'b0;
         dbg_data_o   <= 32'h0;
         fetch_cnt_o  <= '0;
      end else begin
         dbg_gnt_o    <= 1'b0;
         last_dbg_reg <= dbg_grant;
         if (redirect_i) begin
            // Flush: the IF slot becomes a bubble, if_pc keeps its value.
            pc_reg     <= {redirect_pc_i[31:2], 2'b00};
            if_valid_o <= 1'b0;
            if_instr_o <= 32'h0;
            state_reg  <= ST_RUN;
         end else if (dbg_grant) begin
            dbg_data_o <= read_word;
            dbg_gnt_o  <= 1'b1;
            state_reg  <= stall_i ? ST_HOLD : ST_RUN;
         end else if (state_reg == ST_BOOT) begin
            state_reg <= ST_RUN;
         end else if (stall_i) begin
            state_reg <= ST_HOLD;
         end else begin
            if_instr_o  <= read_word;
            if_pc_o     <= pc_reg;
            if_pc4_o    <= pc_reg + 32'd4;
            if_valid_o  <= 1'b1;
            pc_reg      <= pc_reg + 32'd4;
            fetch_cnt_o <= fetch_cnt_o + FETCH_CNT_W'(1);
            state_reg   <= ST_RUN;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 32-word combinational memory model.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_pc, if_pc4, if_instr;
   logic        if_valid;
   logic        dbg_req = 1'b0;
   logic [31:0] dbg_addr = 32'h0;
   logic        dbg_gnt;
   logic [31:0] dbg_data;
   logic [15:0] fetch_cnt;

   logic [31:0] mem [0:31];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   // Memory model aliases above 0x7C, so a non-zero word reaches the DUT there.
   assign imem_instr = mem[imem_addr[6:2]];

   imem_fetch_ctrl #(
      .RESET_PC    (32'h0),
      .MEM_WORDS   (32),
      .FETCH_CNT_W (16)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_addr_o   (imem_addr),
      .imem_instr_i  (imem_instr),
      .if_pc_o       (if_pc),
      .if_pc4_o      (if_pc4),
      .if_instr_o    (if_instr),
      .if_valid_o    (if_valid),
      .dbg_req_i     (dbg_req),
      .dbg_addr_i    (dbg_addr),
      .dbg_gnt_o     (dbg_gnt),
      .dbg_data_o    (dbg_data),
      .fetch_cnt_o   (fetch_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end else begin
         $display("ok   %s: %h", tag, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic valid, input logic [15:0] cnt);
      check({tag, ".pc"},    if_pc,    pc);
      check({tag, ".pc4"},   if_pc4,   pc + 32'd4);
      check({tag, ".instr"}, if_instr, instr);
      check({tag, ".valid"}, {31'h0, if_valid}, {31'h0, valid});
      check({tag, ".cnt"},   {16'h0, fetch_cnt}, {16'h0, cnt});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101;

      // Reset
      step();
      check_if("reset", 32'h0, 32'h0, 1'b0, 16'd0);
      check("reset.gnt",  {31'h0, dbg_gnt}, 32'h0);
      check("reset.data", dbg_data, 32'h0);
      rst = 1'b0;
      step();
      check_if("boot", 32'h0, 32'h0, 1'b0, 16'd0);

      // A, B fetched
      step(); check_if("fetchA", 32'h0, mem[0], 1'b1, 16'd1);
      step(); check_if("fetchB", 32'h4, mem[1], 1'b1, 16'd2);

      // Stall three cycles while B is held
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_if("stallB", 32'h4, mem[1], 1'b1, 16'd2);
         check("stall.addr", imem_addr, 32'h8);
      end
      stall = 1'b0;
      step(); check_if("fetchC", 32'h8, mem[2], 1'b1, 16'd3);
      step(); check_if("fetchD", 32'hC, mem[3], 1'b1, 16'd4);

      // Stall + redirect in same cycle, misaligned target 0x12 -> 0x10
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h12;
      step();
      stall = 1'b0; redirect = 1'b0;
      #1;
      check_if("redir", 32'hC, 32'h0, 1'b0, 16'd4);
      check("redir.addr", imem_addr, 32'h10);
      step(); check_if("redirW4", 32'h10, mem[4], 1'b1, 16'd5);

      // Debug requests held, alternating with fetch
      dbg_req = 1'b1; dbg_addr = 32'h0E;
      #1; check("dbg.addr0", imem_addr, 32'hC);
      step();
      check("dbg.gnt1",  {31'h0, dbg_gnt}, 32'h1);
      check("dbg.data1", dbg_data, mem[3]);
      check_if("dbg.hold1", 32'h10, mem[4], 1'b1, 16'd5);
      check("dbg.addr1", imem_addr, 32'h14);
      step();
      check("dbg.gnt2", {31'h0, dbg_gnt}, 32'h0);
      check_if("dbg.fetch5", 32'h14, mem[5], 1'b1, 16'd6);
      check("dbg.addr2", imem_addr, 32'hC);
      step();
      check("dbg.gnt3",  {31'h0, dbg_gnt}, 32'h1);
      check("dbg.data3", dbg_data, mem[3]);
      step();
      dbg_req = 1'b0;
      check("dbg.gnt4", {31'h0, dbg_gnt}, 32'h0);
      check_if("dbg.fetch6", 32'h18, mem[6], 1'b1, 16'd7);

      // End of memory
      redirect = 1'b1; redirect_pc = 32'h7E;
      step();
      redirect = 1'b0;
      check_if("redir7C", 32'h18, 32'h0, 1'b0, 16'd7);
      step(); check_if("word31", 32'h7C, mem[31], 1'b1, 16'd8);
      step(); check_if("oor80", 32'h80, 32'h0, 1'b1, 16'd9);
      dbg_req = 1'b1; dbg_addr = 32'h200;
      #1; check("dbgoor.addr", imem_addr, 32'h200);
      step();
      dbg_req = 1'b0;
      check("dbgoor.gnt",  {31'h0, dbg_gnt}, 32'h1);
      check("dbgoor.data", dbg_data, 32'h0);
      step();
      check("dbgoor.pulse", {31'h0, dbg_gnt}, 32'h0);

      // Reset while in HOLD with a pending debug request
      stall = 1'b1;
      step();
      dbg_req = 1'b1; dbg_addr = 32'h4; rst = 1'b1;
      step();
      check_if("rst2", 32'h0, 32'h0, 1'b0, 16'd0);
      check("rst2.gnt",  {31'h0, dbg_gnt}, 32'h0);
      check("rst2.data", dbg_data, 32'h0);
      rst = 1'b0; stall = 1'b0;
      #1; check("boot2.addr", imem_addr, 32'h0);
      step();
      check("boot2.gnt", {31'h0, dbg_gnt}, 32'h0);
      check_if("boot2", 32'h0, 32'h0, 1'b0, 16'd0);
      dbg_req = 1'b0;
      step(); check_if("boot2.A", 32'h0, mem[0], 1'b1, 16'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
